// File: rtl/data_mem_lsu.sv
// Load/store unit with a private word-organised data memory.
// Supports RISC-V byte/halfword/word accesses with a configurable fixed access latency.
module data_mem_lsu #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] adr,
  input  logic [2:0]        funct3,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              err
);

  localparam int DEPTH = 1 << (ADDR_W - 2);
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              we_reg;
  logic [ADDR_W-1:0] adr_reg;
  logic [2:0]        f3_reg;
  logic [31:0]       wdata_reg;
  logic              err_reg;
  logic [31:0]       rdata_reg;

  logic [31:0] mem [DEPTH];

  // The access is carried out from live inputs when it completes at the accept
  // edge (error or zero latency), otherwise from the captured request.
  logic              a_we;
  logic [ADDR_W-1:0] a_adr;
  logic [2:0]        a_f3;
  logic [31:0]       a_wdata;
  logic [ADDR_W-3:0] a_idx;
  logic [1:0]        a_lane;
  logic              a_legal, a_misalign, a_err;
  logic              accept, enter_resp, mem_we;
  logic [3:0]        wmask;
  logic [31:0]       wword, rd_word, load_val;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;

  always_comb begin
    a_we    = (state_reg == IDLE) ? we     : we_reg;
    a_adr   = (state_reg == IDLE) ? adr    : adr_reg;
    a_f3    = (state_reg == IDLE) ? funct3 : f3_reg;
    a_wdata = (state_reg == IDLE) ? wdata  : wdata_reg;
  end

  assign a_idx  = a_adr[ADDR_W-1:2];
  assign a_lane = a_adr[1:0];

  always_comb begin
    a_legal = 1'b0;
    case (a_f3)
      3'b000, 3'b001, 3'b010: a_legal = 1'b1;
      3'b100, 3'b101:         a_legal = ~a_we;
      default:                a_legal = 1'b0;
    endcase
    a_misalign = 1'b0;
    case (a_f3[1:0])
      2'b01:   a_misalign = a_adr[0];
      2'b10:   a_misalign = |a_adr[1:0];
      default: a_misalign = 1'b0;
    endcase
    a_err = ~a_legal | a_misalign;
  end

  assign accept = (state_reg == IDLE) && req;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    enter_resp = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (a_err || LAT == 4'd0) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = LAT;
          end
        end
      end
      WAIT: begin
        // Leaving on the decrement that reaches zero places done LATENCY+1 cycles after accept.
        if (cnt_reg <= 4'd1) begin
          state_next = RESP;
          cnt_next   = 4'd0;
          enter_resp = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wmask = 4'b1111;
    wword = a_wdata;
    case (a_f3[1:0])
      2'b00: begin
        wmask = 4'b0001 << a_lane;
        wword = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        wmask = a_adr[1] ? 4'b1100 : 4'b0011;
        wword = {2{a_wdata[15:0]}};
      end
      default: begin
        wmask = 4'b1111;
        wword = a_wdata;
      end
    endcase
  end

  assign rd_word = mem[a_idx];
  assign rd_byte = rd_word[{a_lane, 3'b000} +: 8];
  assign rd_half = a_adr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (a_f3)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_val = {24'd0, rd_byte};
      3'b101:  load_val = {16'd0, rd_half};
      default: load_val = rd_word;
    endcase
  end

  // rst_n gates the write so an accept seen while reset is held can never commit.
  assign mem_we = enter_resp && a_we && !a_err && rst_n;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mem[a_idx][i*8 +: 8] <= wword[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      we_reg    <= 1'b0;
      adr_reg   <= '0;
      f3_reg    <= 3'd0;
      wdata_reg <= 32'd0;
      err_reg   <= 1'b0;
      rdata_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        we_reg    <= we;
        adr_reg   <= adr;
        f3_reg    <= funct3;
        wdata_reg <= wdata;
      end
      if (enter_resp) begin
        err_reg   <= a_err;
        rdata_reg <= (a_err || a_we) ? 32'd0 : load_val;
      end
    end
  end

  assign ready = (state_reg == IDLE);
  assign done  = (state_reg == RESP);
  assign err   = (state_reg == RESP) && err_reg;
  assign rdata = rdata_reg;

endmodule

// File: doc/data_mem_lsu.md
DATA_MEM_LSU -- requirements
Module: data_mem_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, byte-address width; memory depth is 2^(ADDR_W-2) 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles per access; legal range 0..15.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  1  access request, sampled only while ready=1.
REQ-006 SHALL have port we  input  1  1=store, 0=load.
REQ-007 SHALL have port adr  input  ADDR_W  byte address.
REQ-008 SHALL have port funct3  input  3  RISC-V access size/sign code.
REQ-009 SHALL have port wdata  input  32  store data, LSB-aligned.
REQ-010 SHALL have port ready  output  1  block idle, can accept req.
REQ-011 SHALL have port rdata  output  32  load result, sign/zero-extended.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port err  output  1  completion with error; valid only when done=1.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; ready=1 only in IDLE.
REQ-015 SHALL accept a request at an edge where req=1 and ready=1, capturing we, adr, funct3, wdata into internal registers; req while ready=0 SHALL be ignored.
REQ-016 SHALL decode loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores: 000 sb, 001 sh, 010 sw; any other code is illegal.
REQ-017 SHALL flag error when funct3 is illegal, halfword with adr[0]=1, or word with adr[1:0]!=00.
REQ-018 On error: IDLE -> RESP directly at accept edge; no memory write; done=1, err=1, rdata=0 in RESP.
REQ-019 On legal access: IDLE -> WAIT (counter loaded with LATENCY) if LATENCY>0, else IDLE -> RESP; WAIT decrements each cycle, WAIT -> RESP on the edge where counter reaches 0.
REQ-020 SHALL perform the memory access on the edge entering RESP; done pulses for exactly one cycle, LATENCY+1 cycles after the accept edge.
REQ-021 RESP -> IDLE unconditionally next edge; throughput one access per LATENCY+2 cycles.
REQ-022 Word index = adr[ADDR_W-1:2]; byte lane = adr[1:0]; halfword lane = adr[1].
REQ-023 Stores SHALL update only addressed bytes (sb 1 byte, sh 2, sw 4); other bytes of the word unchanged.
REQ-024 Loads SHALL extract addressed byte/halfword; lb/lh sign-extend bit 7/15, lbu/lhu zero-extend.
REQ-025 Store completion SHALL set rdata=0, err=0.
REQ-026 rdata SHALL hold its value from done until the next completion.
REQ-027 Read-after-write to same address SHALL return the stored value (write committed before next accept).

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, counter 0, ready=1, done=0, err=0, rdata=0.
REQ-029 Reset during WAIT SHALL discard the pending access; no memory write occurs.
REQ-030 Memory array contents SHALL NOT be affected by reset.

Verification
REQ-031 LATENCY=2: sw adr=0x004 wdata=0xDEADBEEF, then lw adr=0x004 -> done 3 cycles after each accept, rdata=0xDEADBEEF, err=0.
REQ-032 sb adr=0x005 wdata=0x80 over 0xDEADBEEF, then lb 0x005 -> 0xFFFFFF80; lbu 0x005 -> 0x00000080; lw 0x004 -> 0xDEAD80EF.
REQ-033 lh adr=0x003 and lw adr=0x006 and funct3=011 -> done 1 cycle after accept, err=1, rdata=0, memory unchanged.
REQ-034 sw adr=0x008 wdata=0x12345678, rst_n pulsed low one cycle after accept -> ready=1 immediately, later lw 0x008 returns prior contents.
REQ-035 req held high continuously -> accepts spaced LATENCY+2 cycles; req during WAIT/RESP not accepted.
REQ-036 LATENCY=0 build: sh adr=0x00A wdata=0x0000BEEF then lhu 0x00A -> done 1 cycle after accept, rdata=0x0000BEEF; lh -> 0xFFFFBEEF.
